multicycle_ctrl: RTL

Control FSM that sequences a multi-cycle RV32 subset datapath over one shared single-port memory. The supported subset is R-type, I-type ALU, lw, sw and beq. The block drives mux selects, write strobes, ALUOp and the memory request. It replaces the single-cycle opcode decoder and sits beside ALU_Control, which still consumes alu_op_o. It waits on a memory acknowledge, enforces a timeout, and traps on illegal opcodes.

---
 rtl/multicycle_ctrl.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/multicycle_ctrl.sv
// rtl/multicycle_ctrl.sv - control FSM for a multi-cycle RV32 subset datapath over one shared memory
module multicycle_ctrl #(
  parameter int unsigned ACK_TIMEOUT = 16,
  parameter int unsigned CNT_W       = 8
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [6:0] opcode_i,
  input  logic       zero_i,
  input  logic       mem_ack_i,
  output logic       mem_req_o,
  output logic       mem_we_o,
  output logic       iord_o,
  output logic       ir_write_o,
  output logic       pc_write_o,
  output logic       pc_src_o,
  output logic       alu_src_a_o,
  output logic [1:0] alu_src_b_o,
  output logic [1:0] alu_op_o,
  output logic       reg_write_o,
  output logic       mem_to_reg_o,
  output logic [2:0] state_o,
  output logic       trap_o,
  output logic       retire_o
);

  localparam logic [2:0] S_FETCH  = 3'd0;
  localparam logic [2:0] S_DECODE = 3'd1;
  localparam logic [2:0] S_EXEC   = 3'd2;
  localparam logic [2:0] S_MEM    = 3'd3;
  localparam logic [2:0] S_WB     = 3'd4;
  localparam logic [2:0] S_TRAP   = 3'd7;

  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;

  localparam logic [CNT_W:0] TIMEOUT_LIM = ACK_TIMEOUT[CNT_W:0];

  logic [2:0]       state_q, state_d;
  logic [6:0]       opcode_q, opcode_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W:0]   cnt_inc;
  logic             waiting;
  logic             timed_out;
  logic             opcode_legal;

  // State, latched opcode and ack-wait counter
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= S_FETCH;
      opcode_q <= 7'd0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      opcode_q <= opcode_d;
      cnt_q    <= cnt_d;
    end
  end

  // Wait tracking: a request cycle without ack counts toward the timeout; the cycle that
  // would reach the limit traps unless the ack arrives in that same cycle
  always_comb begin
    opcode_legal = (opcode_i == OP_R) || (opcode_i == OP_I) || (opcode_i == OP_LW) ||
                   (opcode_i == OP_SW) || (opcode_i == OP_BEQ);
    waiting      = ((state_q == S_FETCH) || (state_q == S_MEM)) && !mem_ack_i;
    cnt_inc      = {1'b0, cnt_q} + {{CNT_W{1'b0}}, 1'b1};
    timed_out    = (TIMEOUT_LIM != '0) && waiting && (cnt_inc >= TIMEOUT_LIM);
  end

  // Next-state, opcode latch and counter update
  always_comb begin
    state_d  = state_q;
    opcode_d = opcode_q;
    case (state_q)
      S_FETCH: begin
        if (mem_ack_i)      state_d = S_DECODE;
        else if (timed_out) state_d = S_TRAP;
      end
      S_DECODE: begin
        opcode_d = opcode_i;
        state_d  = opcode_legal ? S_EXEC : S_TRAP;
      end
      S_EXEC: begin
        case (opcode_q)
          OP_R, OP_I:   state_d = S_WB;
          OP_LW, OP_SW: state_d = S_MEM;
          OP_BEQ:       state_d = S_FETCH;
          default:      state_d = S_TRAP;
        endcase
      end
      S_MEM: begin
        if (mem_ack_i)      state_d = (opcode_q == OP_SW) ? S_FETCH : S_WB;
        else if (timed_out) state_d = S_TRAP;
      end
      S_WB:    state_d = S_FETCH;
      S_TRAP:  state_d = S_TRAP;
      default: state_d = S_TRAP;
    endcase

    // Any state change restarts the count, so entry into FETCH or MEM starts from zero
    if (state_d != state_q) cnt_d = '0;
    else if (waiting)       cnt_d = cnt_inc[CNT_W] ? cnt_q : cnt_inc[CNT_W-1:0];
    else                    cnt_d = cnt_q;
  end

  // Datapath controls; ack-qualified strobes are Mealy, everything is held low during reset
  always_comb begin
    mem_req_o    = 1'b0;
    mem_we_o     = 1'b0;
    iord_o       = 1'b0;
    ir_write_o   = 1'b0;
    pc_write_o   = 1'b0;
    pc_src_o     = 1'b0;
    alu_src_a_o  = 1'b0;
    alu_src_b_o  = 2'b00;
    alu_op_o     = 2'b00;
    reg_write_o  = 1'b0;
    mem_to_reg_o = 1'b0;
    trap_o       = 1'b0;
    retire_o     = 1'b0;
    state_o      = state_q;
    case (state_q)
      S_FETCH: begin
        mem_req_o   = 1'b1;
        alu_src_b_o = 2'b01;
        ir_write_o  = mem_ack_i;
        pc_write_o  = mem_ack_i;
      end
      S_DECODE: alu_src_b_o = 2'b10;
      S_EXEC: begin
        alu_src_a_o = 1'b1;
        case (opcode_q)
          OP_R: alu_op_o = 2'b10;
          OP_I: begin
            alu_src_b_o = 2'b10;
            alu_op_o    = 2'b11;
          end
          OP_LW, OP_SW: alu_src_b_o = 2'b10;
          OP_BEQ: begin
            alu_op_o   = 2'b01;
            pc_src_o   = 1'b1;
            pc_write_o = zero_i;
            retire_o   = 1'b1;
          end
          default: alu_src_a_o = 1'b0;
        endcase
      end
      S_MEM: begin
        mem_req_o = 1'b1;
        iord_o    = 1'b1;
        mem_we_o  = (opcode_q == OP_SW);
        retire_o  = mem_ack_i && (opcode_q == OP_SW);
      end
      S_WB: begin
        reg_write_o  = 1'b1;
        mem_to_reg_o = (opcode_q == OP_LW);
        retire_o     = 1'b1;
      end
      S_TRAP:  trap_o = 1'b1;
      default: ;
    endcase

    if (rst_i) begin
      mem_req_o    = 1'b0;
      mem_we_o     = 1'b0;
      iord_o       = 1'b0;
      ir_write_o   = 1'b0;
      pc_write_o   = 1'b0;
      pc_src_o     = 1'b0;
      alu_src_a_o  = 1'b0;
      alu_src_b_o  = 2'b00;
      alu_op_o     = 2'b00;
      reg_write_o  = 1'b0;
      mem_to_reg_o = 1'b0;
      trap_o       = 1'b0;
      retire_o     = 1'b0;
    end
  end

endmodule
